aes_enc_iter: RTL and testbench
===============================

Name: aes_enc_iter

Overview:
- Iterative AES-128/192/256 encryption core, parametrised by key size.
- Computes one round per clock and expands the key schedule on the fly.
- Uses a valid/ready handshake on both input and output.
- Successor to the fixed AES-128 `round` block; sits between the host block/key registers and the ciphertext consumer.

Parameters:
- KEY_BITS, 128, key length: 128, 192 or 256. Any other value is an elaboration error.
- NK, KEY_BITS/32, derived key length in words (4/6/8). Localparam, not overridable.
- NR, NK+6, derived round count (10/12/14). Localparam.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  plaintext and key present
- in_ready  out  1  core idle, can accept
- in_data  in  128  plaintext, byte 0 in bits [127:120] (FIPS-197 order)
- in_key  in  KEY_BITS  cipher key, word w0 in the MSBs
- out_valid  out  1  ciphertext valid
- out_ready  in  1  consumer accepts
- out_data  out  128  ciphertext

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, state register=0, round counter=0, FSM=IDLE. Reset is asynchronous: it asserts immediately and releases on clk.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state <= in_data ^ in_key[KEY_BITS-1 -: 128] (initial AddRoundKey).
  - Load the key window with all NK words of in_key; set word index i=4 and round r=1; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: state <= SubBytes → ShiftRows → MixColumns → AddRoundKey(w[4r..4r+3]).
  - MixColumns is skipped when r==NR.
  - r increments by 1 per cycle.
- Key schedule, generated in the same cycle the words are consumed:
  - Four new words w[i..i+3] per cycle.
  - Each word is w[j] = w[j-NK] ^ t.
  - t = SubWord(RotWord(w[j-1]))^Rcon[j/NK] if j%NK==0.
  - t = SubWord(w[j-1]) if NK==8 && j%NK==4.
  - Otherwise t = w[j-1].
  - The words may chain within one cycle (w[j-1] may be a word produced that cycle).
  - Window shifts by 4 words per cycle; i += 4.
- Completion: after the r==NR update, out_data <= final state, out_valid <= 1, FSM → HOLD.
- Latency: NR+1 cycles from the accepting edge to out_valid=1 (11/13/15).
- HOLD:
  - out_data and out_valid stay stable until out_ready=1.
  - On the edge with out_valid&&out_ready: out_valid <= 0, FSM → IDLE, in_ready=1 from the next cycle.
  - Throughput: no back-to-back acceptance in the same cycle as the output handshake.
- in_data/in_key are sampled only on the accepting edge; later changes are ignored.
- in_valid while busy: ignored, no queueing, in_ready=0. The source must hold in_valid until it is accepted.
- Reset mid-RUN or mid-HOLD: the operation is aborted, no out_valid is produced, and the FSM returns to IDLE.
- out_ready while out_valid=0: no effect.

Optional Feature:
- Macro AES_ROUND_TRACE_EN.
- Defined: extra outputs
  - dbg_state [127:0]: live state register.
  - dbg_round [3:0]: r, 0 in IDLE/HOLD.
  - dbg_rkey [127:0]: round key applied in the current cycle.
  - These serve waveform tracing against the FIPS-197 appendix round tables.
- Undefined: these ports and their logic are absent; functional behaviour is identical.

Decomposition:
- Package aes_pkg:
  - S-box constant table.
  - Rcon table (10 entries).
  - Functions xtime, mix_column, shift_rows, sub_word, rot_word.
  - Localparam helpers nk_of(KEY_BITS) and nr_of(KEY_BITS).
- One sub-module aes_sbox: one byte in, one byte out, combinational, instanced 16× for the state and 4 per key word.

Test Plan:
- KEY_BITS=128:
  - Stimulus: in_data=00112233445566778899aabbccddeeff, in_key=000102030405060708090a0b0c0d0e0f.
  - Required: out_data=69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid exactly 11 cycles after acceptance.
- KEY_BITS=192:
  - Stimulus: same plaintext, key 000102…1617.
  - Required: dda97ca4864cdfe06eaf70a0ec0d7191 at 13 cycles.
- KEY_BITS=256:
  - Stimulus: same plaintext, key 000102…1e1f.
  - Required: 8ea2b7ca516745bfeafc49904b496089 at 15 cycles.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after done, and pulse in_valid with a new block meanwhile.
  - Required: out_data stable, in_ready=0, new block not accepted; after out_ready=1, the new block is accepted the following cycle and yields the correct ciphertext.
- Reset mid-operation:
  - Stimulus: assert reset at round 5 between clock edges.
  - Required: out_valid=0 and in_ready=1 immediately (asynchronous); no spurious output afterwards; the next block encrypts correctly.
- Input change after accept:
  - Stimulus: change in_data/in_key to random values one cycle after acceptance.
  - Required: ciphertext still matches the originally sampled vector.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box and Rcon tables, byte/column/state helpers,
// key-size derivations and the controller state encoding.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } aes_fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Rcon[1..10] stored at index 0..9.
  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic int nk_of(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h00;
    if (idx >= 4'd1 && idx <= 4'd10) r = RCON[idx - 4'd1];
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes a0..a3 sit MSB first.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    return o;
  endfunction

  // Byte n of the state is row n%4, column n/4; row r rotates left by r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte, purely combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128/192/256 encryption core, one round per clock, key
// schedule expanded on the fly. Valid/ready on input and output.
// Optional round trace outputs are built when AES_ROUND_TRACE_EN is defined.
//
// state | meaning
// IDLE  | in_ready high, waiting for a block; initial AddRoundKey on accept
// RUN   | one cipher round per cycle, rounds 1..NR
// HOLD  | ciphertext presented, waiting for out_ready
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [KEY_BITS-1:0] in_key,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef AES_ROUND_TRACE_EN
  output logic [127:0]        dbg_state,
  output logic [3:0]          dbg_round,
  output logic [127:0]        dbg_rkey,
`endif
  output logic [127:0]        out_data
);

  localparam int NK = nk_of(KEY_BITS);
  localparam int NR = nr_of(KEY_BITS);
  localparam logic [5:0] NK6 = 6'(NK);
  localparam logic [3:0] NR4 = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_enc_iter: KEY_BITS must be 128, 192 or 256");
  end

  aes_fsm_e            fsm_q, fsm_d;
  logic [127:0]        state_q, state_d;
  logic [KEY_BITS-1:0] win_q, win_d;
  logic [3:0]          rnd_q, rnd_d;
  logic [5:0]          gj_q, gj_d;
  logic [127:0]        out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  // The window holds the last NK schedule words; gj_q is the absolute index
  // of the first word generated this cycle. Window plus the four new words
  // always place the current round key at words 4..7 of that extended view.
  logic [127:0]        sb_state;
  logic [127:0]        sr_state;
  logic [127:0]        round_out;
  logic [127:0]        rkey;
  logic [KEY_BITS-1:0] win_next;
  logic [31:0]         nw0, nw1, nw2, nw3;
  logic                last_round;

  for (genvar b = 0; b < 16; b++) begin : g_sb_state
    aes_sbox u_sbox (.byte_i(state_q[8*b +: 8]), .byte_o(sb_state[8*b +: 8]));
  end

  for (genvar k = 0; k < 4; k++) begin : g_kw
    logic [31:0] prev, sbi, sbo, tw, nw;
    logic [5:0]  jk;
    logic        rot_en, sub_en;
    logic [3:0]  rc_idx;

    if (k == 0) begin : g_p0
      assign prev = win_q[31:0];
    end else if (k == 1) begin : g_p1
      assign prev = nw0;
    end else if (k == 2) begin : g_p2
      assign prev = nw1;
    end else begin : g_p3
      assign prev = nw2;
    end

    assign jk     = gj_q + 6'(k);
    assign rot_en = (jk % NK6) == 6'd0;
    assign sub_en = (NK == 8) && ((jk % NK6) == 6'd4);
    assign rc_idx = 4'(jk / NK6);
    assign sbi    = rot_en ? rot_word(prev) : prev;

    for (genvar b = 0; b < 4; b++) begin : g_sb
      aes_sbox u_sbox (.byte_i(sbi[8*b +: 8]), .byte_o(sbo[8*b +: 8]));
    end

    assign tw = rot_en ? (sbo ^ {rcon_of(rc_idx), 24'h000000})
                       : (sub_en ? sbo : prev);
    assign nw = win_q[KEY_BITS-1-32*k -: 32] ^ tw;

    if (k == 0) begin : g_o0
      assign nw0 = nw;
    end else if (k == 1) begin : g_o1
      assign nw1 = nw;
    end else if (k == 2) begin : g_o2
      assign nw2 = nw;
    end else begin : g_o3
      assign nw3 = nw;
    end
  end

  if (NK == 4) begin : g_win4
    assign win_next = {nw0, nw1, nw2, nw3};
  end else begin : g_winx
    assign win_next = {win_q[KEY_BITS-129:0], nw0, nw1, nw2, nw3};
  end

  assign rkey       = win_next[KEY_BITS-1 -: 128];
  assign last_round = (rnd_q == NR4);
  assign sr_state   = shift_rows(sb_state);
  assign round_out  = (last_round ? sr_state : mix_columns(sr_state)) ^ rkey;

  assign in_ready  = (fsm_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Next-state and datapath update for accept, round iteration and handoff.
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    win_d       = win_q;
    rnd_d       = rnd_q;
    gj_d        = gj_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = in_data ^ in_key[KEY_BITS-1 -: 128];
          win_d   = in_key;
          rnd_d   = 4'd1;
          gj_d    = NK6;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = round_out;
        win_d   = win_next;
        rnd_d   = rnd_q + 4'd1;
        gj_d    = gj_q + 6'd4;
        if (last_round) begin
          out_data_d  = round_out;
          out_valid_d = 1'b1;
          rnd_d       = 4'd0;
          fsm_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm_q <= ST_IDLE;
    else       fsm_q <= fsm_d;
  end

  // Cipher state, key window, counters and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= '0;
      win_q       <= '0;
      rnd_q       <= '0;
      gj_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      rnd_q       <= rnd_d;
      gj_q        <= gj_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef AES_ROUND_TRACE_EN
  assign dbg_state = state_q;
  assign dbg_round = (fsm_q == ST_RUN) ? rnd_q : 4'd0;
  assign dbg_rkey  = (fsm_q == ST_RUN)  ? rkey :
                     (fsm_q == ST_IDLE) ? in_key[KEY_BITS-1 -: 128] : 128'h0;
`endif

endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed bench for aes_enc_iter: FIPS-197 vectors for all three key sizes,
// latency, backpressure, asynchronous reset mid-run, input change after accept.
module tb_aes_enc_iter;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   in_valid_v;
  logic [2:0]   in_ready_v;
  logic [2:0]   out_valid_v;
  logic [2:0]   out_ready_v;
  logic [127:0] in_data;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic [127:0] out_data0, out_data1, out_data2;
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  aes_enc_iter #(.KEY_BITS(128)) u_aes128 (
    .clk(clk), .reset(reset), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data), .in_key(key128), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .out_data(out_data0));

  aes_enc_iter #(.KEY_BITS(192)) u_aes192 (
    .clk(clk), .reset(reset), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data), .in_key(key192), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .out_data(out_data1));

  aes_enc_iter #(.KEY_BITS(256)) u_aes256 (
    .clk(clk), .reset(reset), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_data(in_data), .in_key(key256), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .out_data(out_data2));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rd_out(input int sel);
    case (sel)
      0:       return out_data0;
      1:       return out_data1;
      default: return out_data2;
    endcase
  endfunction

  // Keys are passed left-aligned in 256 bits.
  task automatic drive_key(input int sel, input logic [255:0] k);
    case (sel)
      0:       key128 = k[255:128];
      1:       key192 = k[255:64];
      default: key256 = k;
    endcase
  endtask

  // Called just after a negedge. Offers a block, waits for acceptance and
  // for out_valid, then checks latency and ciphertext. Leaves out_valid up.
  task automatic start_and_wait(input int sel, input logic [127:0] pt,
                                input logic [255:0] k, input logic [127:0] exp,
                                input int exp_lat, input string tag,
                                input bit scramble);
    int w;
    int lat;
    in_data = pt;
    drive_key(sel, k);
    in_valid_v[sel] = 1'b1;
    w = 0;
    while (!in_ready_v[sel] && w < 100) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_accept"}, 128'(in_ready_v[sel]), 128'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        in_valid_v[sel] = 1'b0;
        if (scramble) begin
          in_data = {$urandom, $urandom, $urandom, $urandom};
          drive_key(sel, {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom});
        end
      end
    end while (!out_valid_v[sel] && lat < 60);
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check({tag, "_data"}, rd_out(sel), exp);
  endtask

  task automatic consume(input int sel, input string tag);
    out_ready_v[sel] = 1'b1;
    @(negedge clk);
    out_ready_v[sel] = 1'b0;
    check({tag, "_valid_drop"}, 128'(out_valid_v[sel]), 128'd0);
    check({tag, "_ready_back"}, 128'(in_ready_v[sel]), 128'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    in_valid_v  = 3'b000;
    out_ready_v = 3'b000;
    in_data     = '0;
    key128      = '0;
    key192      = '0;
    key256      = '0;

    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("rst_in_ready", 128'(in_ready_v[s]), 128'd1);
      check("rst_out_valid", 128'(out_valid_v[s]), 128'd0);
      check("rst_out_data", rd_out(s), 128'h0);
    end
    reset = 1'b0;
    @(negedge clk);

    start_and_wait(0, PT, KEY, CT128, 11, "aes128", 1'b0);
    consume(0, "aes128");

    // out_ready with nothing pending must not disturb an idle core.
    out_ready_v[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_oready_valid", 128'(out_valid_v[1]), 128'd0);
      check("idle_oready_ready", 128'(in_ready_v[1]), 128'd1);
    end
    out_ready_v[1] = 1'b0;

    start_and_wait(1, PT, KEY, CT192, 13, "aes192", 1'b0);
    consume(1, "aes192");
    start_and_wait(2, PT, KEY, CT256, 15, "aes256", 1'b0);
    consume(2, "aes256");

    // Backpressure: result held 20 cycles while a new block is offered.
    start_and_wait(0, PT, KEY, CT128, 11, "bp_first", 1'b0);
    for (int c = 0; c < 20; c++) begin
      if (c == 3) begin
        in_data = PT_B;
        drive_key(0, KEY_B);
        in_valid_v[0] = 1'b1;
      end
      if (c == 5)  in_valid_v[0] = 1'b0;
      if (c == 10) in_valid_v[0] = 1'b1;
      @(negedge clk);
      check("bp_hold_data", out_data0, CT128);
      check("bp_hold_valid", 128'(out_valid_v[0]), 128'd1);
      check("bp_in_ready", 128'(in_ready_v[0]), 128'd0);
    end
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
    check("bp_valid_drop", 128'(out_valid_v[0]), 128'd0);
    check("bp_ready_next", 128'(in_ready_v[0]), 128'd1);
    start_and_wait(0, PT_B, KEY_B, CT_B, 11, "bp_second", 1'b0);
    consume(0, "bp_second");

    // Asynchronous reset while round 5 is pending.
    in_data = PT_B;
    drive_key(0, KEY_B);
    in_valid_v[0] = 1'b1;
    check("rst_mid_accept", 128'(in_ready_v[0]), 128'd1);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_busy", 128'(in_ready_v[0]), 128'd0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_valid", 128'(out_valid_v[0]), 128'd0);
    check("rst_mid_ready", 128'(in_ready_v[0]), 128'd1);
    check("rst_mid_data", out_data0, 128'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("rst_no_spurious", 128'(out_valid_v[0]), 128'd0);
    end
    start_and_wait(0, PT_B, KEY_B, CT_B, 11, "rst_after", 1'b0);
    consume(0, "rst_after");

    // Inputs scrambled one cycle after acceptance.
    start_and_wait(0, PT, KEY, CT128, 11, "chg128", 1'b1);
    consume(0, "chg128");
    start_and_wait(2, PT, KEY, CT256, 15, "chg256", 1'b1);
    consume(2, "chg256");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
